// File: rtl/branch_pkg.sv
// Shared types and constants for branch resolution and the 2-bit branch history table.
// Pure definitions; no logic of its own.
package branch_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_func_e;

    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_MAX   = 2'b11;
    localparam logic [1:0] CTR_MIN   = 2'b00;
    localparam int         PC_STEP   = 4;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
        end
        return (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates the six RV branch conditions from a single borrow-out subtraction.
// Latency: purely combinational. Backpressure: none, no state.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      func3,
    output logic            taken,
    output logic            illegal
);

    logic [XLEN:0] diff;
    logic          eq;
    logic          ltu;
    logic          lt;

    assign diff = {1'b0, a} - {1'b0, b};
    assign eq   = (a == b);
    assign ltu  = diff[XLEN];
    // Differing signs decide signed order directly; otherwise the difference sign is exact.
    assign lt   = (a[XLEN-1] ^ b[XLEN-1]) ? a[XLEN-1] : diff[XLEN-1];

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (func3)
            BEQ:     taken = eq;
            BNE:     taken = !eq;
            BLT:     taken = lt;
            BGE:     taken = !lt;
            BLTU:    taken = ltu;
            BGEU:    taken = !ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches, registers the result, flags mispredicts and trains a 2-bit BHT.
// Latency: 1 cycle issue-to-result. Backpressure: in_ready = !out_valid || out_ready; result holds while stalled.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 64,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_op_a,
    input  logic [XLEN-1:0] in_op_b,
    input  logic [XLEN-1:0] in_imm,
    input  logic [2:0]      in_func3,
    input  logic            in_pred,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic            out_mispred,
    output logic [XLEN-1:0] out_redirect,
    output logic            out_illegal,
    input  logic [XLEN-1:0] lk_pc,
    output logic            lk_taken
);

    logic            cond_taken;
    logic            cond_illegal;
    logic            issue_fire;
    logic [XLEN-1:0] target;
    logic [IDX_W-1:0] in_idx;
    logic [IDX_W-1:0] lk_idx;
    logic            unused_lk_bits;

    logic            out_valid_q,    out_valid_d;
    logic            out_taken_q,    out_taken_d;
    logic [XLEN-1:0] out_target_q,   out_target_d;
    logic            out_mispred_q,  out_mispred_d;
    logic [XLEN-1:0] out_redirect_q, out_redirect_d;
    logic            out_illegal_q,  out_illegal_d;
    logic [1:0]      bht_q [DEPTH];
    logic [1:0]      bht_d [DEPTH];

    branch_cond_eval #(.XLEN(XLEN)) u_cond (
        .a       (in_op_a),
        .b       (in_op_b),
        .func3   (in_func3),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    assign in_ready   = !out_valid_q || out_ready;
    assign issue_fire = in_valid && in_ready;
    assign target     = in_pc + in_imm;
    assign in_idx     = in_pc[IDX_W+1:2];
    assign lk_idx     = lk_pc[IDX_W+1:2];
    // Lookup reads the registered counter, so a same-cycle train is not visible yet.
    assign lk_taken   = bht_q[lk_idx][1];
    assign unused_lk_bits = ^{lk_pc[1:0], lk_pc[XLEN-1:IDX_W+2]};

    always_comb begin
        out_valid_d    = out_valid_q;
        out_taken_d    = out_taken_q;
        out_target_d   = out_target_q;
        out_mispred_d  = out_mispred_q;
        out_redirect_d = out_redirect_q;
        out_illegal_d  = out_illegal_q;
        bht_d          = bht_q;
        if (issue_fire) begin
            out_valid_d    = 1'b1;
            out_taken_d    = cond_taken;
            out_target_d   = target;
            out_mispred_d  = cond_taken != in_pred;
            out_redirect_d = cond_taken ? target : in_pc + XLEN'(PC_STEP);
            out_illegal_d  = cond_illegal;
            if (!cond_illegal) begin
                bht_d[in_idx] = ctr_next(bht_q[in_idx], cond_taken);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_taken_q    <= 1'b0;
            out_target_q   <= '0;
            out_mispred_q  <= 1'b0;
            out_redirect_q <= '0;
            out_illegal_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bht_q[i] <= CTR_RESET;
            end
        end else begin
            out_valid_q    <= out_valid_d;
            out_taken_q    <= out_taken_d;
            out_target_q   <= out_target_d;
            out_mispred_q  <= out_mispred_d;
            out_redirect_q <= out_redirect_d;
            out_illegal_q  <= out_illegal_d;
            bht_q          <= bht_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_taken    = out_taken_q;
    assign out_target   = out_target_q;
    assign out_mispred  = out_mispred_q;
    assign out_redirect = out_redirect_q;
    assign out_illegal  = out_illegal_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (XLEN=32, DEPTH=64) with hand-computed expectations.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_op_a, in_op_b, in_imm;
    logic [2:0]  in_func3;
    logic        in_pred;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_target;
    logic        out_mispred;
    logic [31:0] out_redirect;
    logic        out_illegal;
    logic [31:0] lk_pc;
    logic        lk_taken;

    int checks = 0;
    int errors = 0;
    logic lk_pre;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .DEPTH(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_op_a(in_op_a), .in_op_b(in_op_b), .in_imm(in_imm),
        .in_func3(in_func3), .in_pred(in_pred),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target), .out_mispred(out_mispred),
        .out_redirect(out_redirect), .out_illegal(out_illegal),
        .lk_pc(lk_pc), .lk_taken(lk_taken)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one branch, capture the same-cycle lookup, then clock it in.
    task automatic issue(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [2:0] f3, input logic pred);
        in_valid = 1'b1;
        in_pc    = pc;
        in_op_a  = a;
        in_op_b  = b;
        in_imm   = imm;
        in_func3 = f3;
        in_pred  = pred;
        #1;
        lk_pre = lk_taken;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = '0; in_op_a = '0; in_op_b = '0; in_imm = '0; in_func3 = '0; in_pred = 1'b0;
        lk_pc = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_target", out_target, 32'h0);
        chk("reset_out_redirect", out_redirect, 32'h0);
        chk("reset_lk_taken", lk_taken, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(32'h100, 32'd5, 32'd5, 32'd8, 3'b000, 1'b0);
        chk("beq_valid", out_valid, 1'b1);
        chk("beq_taken", out_taken, 1'b1);
        chk("beq_target", out_target, 32'h108);
        chk("beq_mispred", out_mispred, 1'b1);
        chk("beq_redirect", out_redirect, 32'h108);
        issue(32'h100, 32'd5, 32'd5, 32'd8, 3'b001, 1'b0);
        chk("bne_taken", out_taken, 1'b0);
        chk("bne_mispred", out_mispred, 1'b0);
        chk("bne_redirect", out_redirect, 32'h104);
        issue(32'h100, 32'hFFFF_FFFF, 32'd1, 32'd8, 3'b110, 1'b0);
        chk("bltu_taken", out_taken, 1'b0);
        issue(32'h100, 32'hFFFF_FFFF, 32'd1, 32'd8, 3'b111, 1'b0);
        chk("bgeu_taken", out_taken, 1'b1);
        issue(32'h100, 32'h8000_0000, 32'h7FFF_FFFF, 32'd8, 3'b100, 1'b1);
        chk("blt_ovf_taken", out_taken, 1'b1);
        chk("blt_ovf_mispred", out_mispred, 1'b0);
        issue(32'h100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd8, 3'b101, 1'b0);
        chk("bge_eq_taken", out_taken, 1'b1);

        issue(32'hFFFF_FFF8, 32'd1, 32'd2, 32'd16, 3'b000, 1'b0);
        chk("wrap_target", out_target, 32'h0000_0008);
        chk("wrap_redirect", out_redirect, 32'hFFFF_FFFC);
        chk("wrap_taken", out_taken, 1'b0);
        @(posedge clk); #1;
        chk("drain_valid", out_valid, 1'b0);

        out_ready = 1'b0;
        issue(32'h200, 32'd1, 32'd2, 32'h20, 3'b001, 1'b0);
        in_valid = 1'b1; in_pc = 32'h300; in_op_a = 32'd1; in_op_b = 32'd2;
        in_imm = 32'd4; in_func3 = 3'b000; in_pred = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_target", out_target, 32'h220);
            chk("stall_taken", out_taken, 1'b1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("next_target", out_target, 32'h304);
        chk("next_redirect", out_redirect, 32'h304);
        chk("next_taken", out_taken, 1'b0);
        @(posedge clk); #1;
        chk("idle_valid", out_valid, 1'b0);

        lk_pc = 32'h40;
        issue(32'h40, 32'd0, 32'd0, 32'd4, 3'b000, 1'b1);
        chk("train1_lk_pre", lk_pre, 1'b0);
        issue(32'h40, 32'd0, 32'd0, 32'd4, 3'b000, 1'b1);
        chk("train2_lk_pre", lk_pre, 1'b1);
        issue(32'h40, 32'd0, 32'd0, 32'd4, 3'b000, 1'b1);
        chk("train3_lk_pre", lk_pre, 1'b1);
        issue(32'h40, 32'd0, 32'd0, 32'd4, 3'b000, 1'b1);
        chk("train_sat_lk", lk_taken, 1'b1);

        issue(32'h40, 32'd0, 32'd0, 32'd4, 3'b010, 1'b1);
        chk("illegal_flag", out_illegal, 1'b1);
        chk("illegal_taken", out_taken, 1'b0);
        chk("illegal_mispred", out_mispred, 1'b1);
        issue(32'h40, 32'd0, 32'd1, 32'd4, 3'b000, 1'b0);
        chk("untrain1_lk", lk_taken, 1'b1);
        chk("untrain1_illegal", out_illegal, 1'b0);
        issue(32'h40, 32'd0, 32'd1, 32'd4, 3'b000, 1'b0);
        chk("untrain2_lk", lk_taken, 1'b0);

        lk_pc = 32'h80;
        issue(32'h80, 32'd3, 32'd3, 32'd4, 3'b000, 1'b1);
        issue(32'h80, 32'd3, 32'd3, 32'd4, 3'b000, 1'b1);
        out_ready = 1'b0;
        issue(32'h80, 32'd3, 32'd4, 32'd4, 3'b110, 1'b1);
        chk("pre_rst_valid", out_valid, 1'b1);
        chk("pre_rst_lk", lk_taken, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_taken", out_taken, 1'b0);
        chk("rst_lk_80", lk_taken, 1'b0);
        lk_pc = 32'h40;
        #1;
        chk("rst_lk_40", lk_taken, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
